pipeline_stall_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Combines three hazard sources into one set of stage-control signals:
  - load-use hazard (ID vs EX),
  - taken-branch flush (resolved in ID),
  - multi-cycle data-memory access in MEM, using a req/ack handshake.
- Priority order: memory freeze > load-use stall > branch flush.
- Adds a memory-wait watchdog and saturating stall statistics counters.

---
 rtl/pipeline_stall_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Merges memory freeze, load-use stall and branch flush; adds watchdog and stats.
module pipeline_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rd_i,
    input  logic [REG_W-1:0] ifid_rs1_i,
    input  logic [REG_W-1:0] ifid_rs2_i,
    input  logic             ifid_rs1_used_i,
    input  logic             ifid_rs2_used_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memop_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] lu_stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WW = $clog2(MAX_WAIT);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t          state, state_nxt;
    logic [WW-1:0]   wait_cnt, wait_nxt;
    logic            lu, freeze, lu_bub;

    assign lu = idex_memread_i && (idex_rd_i != '0) &&
                ((ifid_rs1_used_i && idex_rd_i == ifid_rs1_i) ||
                 (ifid_rs2_used_i && idex_rd_i == ifid_rs2_i));

    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        mem_req_o     = 1'b0;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        freeze        = 1'b0;
        lu_bub        = 1'b0;

        unique case (state)
            RUN: begin
                if (exmem_memop_i && !mem_ack_i) begin
                    state_nxt = WAIT;
                    wait_nxt  = WW'(1);
                end
            end
            WAIT: begin
                if (mem_ack_i)
                    state_nxt = RUN;
                else if (wait_cnt == WW'(MAX_WAIT - 1))
                    state_nxt = ERR;
                else
                    wait_nxt = wait_cnt + WW'(1);
            end
            ERR: state_nxt = ERR;
            default: state_nxt = RUN;
        endcase

        mem_req_o = (state == RUN && exmem_memop_i) || (state == WAIT);
        freeze    = mem_req_o && !mem_ack_i;

        if (state == ERR) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (freeze) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (lu) begin
            // branch operands are stale while the load is outstanding
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            lu_bub        = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end

        if (!rst_i) begin
            mem_req_o     = 1'b0;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b1;
            pipe_hold_o   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state           <= RUN;
            wait_cnt        <= '0;
            timeout_o       <= 1'b0;
            lu_stall_cnt_o  <= '0;
            mem_stall_cnt_o <= '0;
            flush_cnt_o     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state_nxt == ERR)
                timeout_o <= 1'b1;
            if (freeze && mem_stall_cnt_o != '1)
                mem_stall_cnt_o <= mem_stall_cnt_o + 1'b1;
            if (lu_bub && lu_stall_cnt_o != '1)
                lu_stall_cnt_o <= lu_stall_cnt_o + 1'b1;
            if (ifid_flush_o && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule
